// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
// State encodings, default widths and master ids.
package reg_arb_pkg;

    localparam int AW_DEF = 7;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_e;

    typedef logic mid_t;

    localparam mid_t M0 = 1'b0;
    localparam mid_t M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic with the last-grant history register.
// Ports: clk, reset_n, req0/req1 in; commit/commit_id record the
// finished winner; any_req/gnt give the winner for the current cycle.
// Build option: REG_ARB_RR_EN selects round-robin, otherwise m0 wins.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic commit,
    input  mid_t commit_id,
    output logic any_req,
    output mid_t gnt
);

`ifdef REG_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Reset to M1 so that m0 wins the first contest.
    mid_t last_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= M1;
        end else if (commit) begin
            last_gnt <= commit_id;
        end
    end

    always_comb begin
        any_req = req0 | req1;
        gnt     = M0;
        unique case (1'b1)
            req0 && req1: gnt = RR_EN ? ~last_gnt : M0;
            req1 && !req0: gnt = M1;
            default:       gnt = M0;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Serialises two masters onto the single-port register bank.
// Ports: clk, reset_n; m0_*/m1_* request/ack/rdata per master;
// rf_* drive the bank (rdata arrives the cycle after rf_rd);
// arb_busy/arb_gnt report state. REG_ARB_RR_EN enables round-robin.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_rd,
    output logic          rf_wr,
    input  logic [DW-1:0] rf_rdata,
    output logic          arb_busy,
    output logic          arb_gnt
);

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic          cmd_wr_q;
    logic          cmd_wr_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    mid_t          gnt_d;
    logic          rf_wr_d;
    logic          rf_rd_d;
    logic          busy_d;
    logic          m0_ack_d;
    logic          m1_ack_d;
    logic          cap0;
    logic          cap1;
    logic          any_req;
    mid_t          win;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (m0_req),
        .req1      (m1_req),
        .commit    (state_q == ST_ACK),
        .commit_id (arb_gnt),
        .any_req   (any_req),
        .gnt       (win)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = cmd_wr_q ? ST_ACK : ST_RDWAIT;
            ST_RDWAIT: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs. The command is taken from
    // the winner on the grant edge so the strobe lines up with ISSUE.
    always_comb begin
        gnt_d    = arb_gnt;
        cmd_wr_d = cmd_wr_q;
        addr_d   = rf_addr;
        wdata_d  = rf_wdata;
        if (state_q == ST_IDLE && any_req) begin
            gnt_d = win;
            if (win == M1) begin
                cmd_wr_d = m1_wr;
                addr_d   = m1_addr;
                wdata_d  = m1_wdata;
            end else begin
                cmd_wr_d = m0_wr;
                addr_d   = m0_addr;
                wdata_d  = m0_wdata;
            end
        end
        rf_wr_d  = (state_d == ST_ISSUE) && cmd_wr_d;
        rf_rd_d  = (state_d == ST_ISSUE) && !cmd_wr_d;
        busy_d   = (state_d != ST_IDLE);
        m0_ack_d = (state_d == ST_ACK) && (gnt_d == M0);
        m1_ack_d = (state_d == ST_ACK) && (gnt_d == M1);
        cap0     = (state_q == ST_RDWAIT) && (arb_gnt == M0);
        cap1     = (state_q == ST_RDWAIT) && (arb_gnt == M1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_wr_q <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
            rf_wr    <= 1'b0;
            rf_rd    <= 1'b0;
            arb_busy <= 1'b0;
            arb_gnt  <= M0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
        end else begin
            cmd_wr_q <= cmd_wr_d;
            rf_addr  <= addr_d;
            rf_wdata <= wdata_d;
            rf_wr    <= rf_wr_d;
            rf_rd    <= rf_rd_d;
            arb_busy <= busy_d;
            arb_gnt  <= gnt_d;
            m0_ack   <= m0_ack_d;
            m1_ack   <= m1_ack_d;
        end
    end

    // Only the winner's read-data register ever changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            if (cap0) m0_rdata <= rf_rdata;
            if (cap1) m1_rdata <= rf_rdata;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter with a behavioural bank,
// a transaction-level reference model and master BFMs.
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m0_req, m0_wr, m1_req, m1_wr;
    logic [6:0] m0_addr, m1_addr, rf_addr;
    logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [7:0] rf_wdata, rf_rdata;
    logic       m0_ack, m1_ack, rf_rd, rf_wr, arb_busy, arb_gnt;

    always #5 clk = ~clk;

    reg_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rd(rf_rd),
        .rf_wr(rf_wr), .rf_rdata(rf_rdata),
        .arb_busy(arb_busy), .arb_gnt(arb_gnt)
    );

    logic [7:0] bank [128] = '{default: 8'h00};

    always @(posedge clk) begin
        if (rf_wr) bank[rf_addr] <= rf_wdata;
        if (rf_rd) rf_rdata <= bank[rf_addr];
    end

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct {
        int         mid;
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         exp_lat;
        logic [7:0] exp_rdata;
    } vec_t;

    int checks = 0;
    int failures = 0;

    bit         req [2];
    bit         wr_v [2];
    logic [6:0] addr_v [2];
    logic [7:0] wdata_v [2];
    txn_t       txq [2][$];
    bit         b2b [2];
    bit         gaps;
    int         req_edge [2];
    int         ack_edge [2];
    int         n_done [2];
    int         edge_n = 0;

    assign m0_req = req[0];
    assign m0_wr = wr_v[0];
    assign m0_addr = addr_v[0];
    assign m0_wdata = wdata_v[0];
    assign m1_req = req[1];
    assign m1_wr = wr_v[1];
    assign m1_addr = addr_v[1];
    assign m1_wdata = wdata_v[1];

    // Transaction-level reference: one transaction at a time, a write
    // lasts 2 visible cycles (ISSUE, ACK), a read 3, then one idle cycle.
    bit         m_busy;
    int         m_k, m_len;
    bit         m_win, m_wr, m_last;
    logic [6:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] shadow [128] = '{default: 8'h00};
    logic [7:0] exp_rd [2];
    int         gnt_log [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d",
                     nm, act, exp, edge_n);
        end
    endtask

    function automatic bit pick(bit r0, bit r1, bit last);
        if (r0 && r1) begin
`ifdef REG_ARB_RR_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_last = 1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
    endtask

    task automatic load(int i);
        txn_t t;
        t = txq[i].pop_front();
        wr_v[i] = t.wr;
        addr_v[i] = t.addr;
        wdata_v[i] = t.wdata;
        req[i] = 1;
        req_edge[i] = edge_n;
    endtask

    task automatic check_outputs();
        bit e_str, e_ack;
        e_str = m_busy && m_k == 0;
        e_ack = m_busy && m_k == m_len - 1;
        if (e_ack && !m_wr) exp_rd[m_win] = shadow[m_addr];
        chk("rf_wr", rf_wr, e_str && m_wr);
        chk("rf_rd", rf_rd, e_str && !m_wr);
        chk("m0_ack", m0_ack, e_ack && !m_win);
        chk("m1_ack", m1_ack, e_ack && m_win);
        chk("arb_busy", arb_busy, m_busy);
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        if (m_busy) chk("arb_gnt", arb_gnt, m_win);
        if (e_str) chk("rf_addr", rf_addr, m_addr);
        if (e_str && m_wr) chk("rf_wdata", rf_wdata, m_wdata);
        if (!reset_n) begin
            chk("rst_rf_addr", rf_addr, 0);
            chk("rst_rf_wdata", rf_wdata, 0);
            chk("rst_arb_gnt", arb_gnt, 0);
        end
    endtask

    task automatic drive();
        bit a;
        if (!reset_n) return;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? m0_ack : m1_ack;
            if (req[i] && a) begin
                n_done[i]++;
                ack_edge[i] = edge_n;
                if (b2b[i] && txq[i].size() > 0) load(i);
                else req[i] = 0;
            end else if (!req[i] && txq[i].size() > 0 &&
                         (!gaps || $urandom_range(0, 2) == 0)) begin
                load(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (!reset_n) begin
            model_reset();
        end else if (m_busy) begin
            m_k++;
            if (m_k == m_len) begin
                m_busy = 0;
                m_last = m_win;
            end
        end else if (req[0] || req[1]) begin
            m_win = pick(req[0], req[1], m_last);
            m_wr = wr_v[m_win];
            m_addr = addr_v[m_win];
            m_wdata = wdata_v[m_win];
            m_len = m_wr ? 2 : 3;
            m_k = 0;
            m_busy = 1;
            gnt_log.push_back(int'(m_win));
            if (m_wr) shadow[m_addr] = m_wdata;
        end
        #1;
        check_outputs();
        drive();
    endtask

    task automatic clear_bfm();
        req[0] = 0;
        req[1] = 0;
        txq[0].delete();
        txq[1].delete();
        n_done[0] = 0;
        n_done[1] = 0;
    endtask

    task automatic run_idle(int max);
        int n;
        n = 0;
        while (txq[0].size() > 0 || txq[1].size() > 0 ||
               req[0] || req[1] || m_busy) begin
            if (n >= max) begin
                checks++;
                failures++;
                $display("FAIL timeout actual=%0d required<%0d", n, max);
                clear_bfm();
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_bfm();
        model_reset();
        step();
        step();
        reset_n = 1;
    endtask

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b1, 7'h05, 8'hA5, 3, 8'h00};
        vecs[1] = '{1, 1'b0, 7'h05, 8'h00, 4, 8'hA5};
        vecs[2] = '{1, 1'b1, 7'h7F, 8'h3C, 3, 8'h00};
        vecs[3] = '{0, 1'b0, 7'h7F, 8'h00, 4, 8'h3C};
        vecs[4] = '{0, 1'b1, 7'h00, 8'hFF, 3, 8'h00};
        vecs[5] = '{1, 1'b0, 7'h00, 8'h00, 4, 8'hFF};
        vecs[6] = '{0, 1'b0, 7'h05, 8'h00, 4, 8'hA5};

        for (int i = 0; i < 2; i++) begin
            wr_v[i] = 0;
            addr_v[i] = 0;
            wdata_v[i] = 0;
            b2b[i] = 0;
        end
        gaps = 0;
        do_reset();

        // Single-master vectors: latency and returned data.
        foreach (vecs[v]) begin
            clear_bfm();
            txq[vecs[v].mid].push_back(
                '{vecs[v].wr, vecs[v].addr, vecs[v].wdata});
            run_idle(20);
            chk("vec_acks", n_done[vecs[v].mid], 1);
            chk("vec_lat", ack_edge[vecs[v].mid] - req_edge[vecs[v].mid] + 1,
                vecs[v].exp_lat);
            if (!vecs[v].wr)
                chk("vec_rdata", vecs[v].mid ? m1_rdata : m0_rdata,
                    vecs[v].exp_rdata);
        end

        // Simultaneous requests after reset: m0 first.
        do_reset();
        gnt_log.delete();
        txq[0].push_back('{1'b1, 7'h10, 8'h11});
        txq[1].push_back('{1'b1, 7'h20, 8'h22});
        run_idle(30);
        chk("t3_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk("t3_first", gnt_log[0], 0);
            chk("t3_second", gnt_log[1], 1);
        end
        chk("t3_bank10", bank[7'h10], 8'h11);
        chk("t3_bank20", bank[7'h20], 8'h22);

        // Both masters requesting continuously.
        clear_bfm();
        gnt_log.delete();
        b2b[0] = 1;
        b2b[1] = 1;
        for (int i = 0; i < 4; i++) begin
            txq[0].push_back('{1'b1, 7'(8'h30 + i), 8'(8'h40 + i)});
            txq[1].push_back('{1'b0, 7'(8'h30 + i), 8'h00});
        end
        run_idle(100);
        chk("t4_ngnt", gnt_log.size(), 8);
        if (gnt_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
`ifdef REG_ARB_RR_EN
                chk("t4_gnt", gnt_log[i], i % 2);
`else
                chk("t4_gnt", gnt_log[i], (i < 4) ? 0 : 1);
`endif
            end
        end
        b2b[0] = 0;
        b2b[1] = 0;

        // Reset while m1's read waits for bank data.
        clear_bfm();
        txq[1].push_back('{1'b0, 7'h30, 8'h00});
        for (int n = 0; n < 10 && !(m_busy && m_k == 1); n++) step();
        chk("t5_rdwait", m_busy && m_k == 1, 1);
        reset_n = 0;
        clear_bfm();
        model_reset();
        #1;
        chk("t5_rf_rd", rf_rd, 0);
        chk("t5_busy", arb_busy, 0);
        chk("t5_m1_ack", m1_ack, 0);
        chk("t5_m1_rdata", m1_rdata, 0);
        chk("t5_m0_rdata", m0_rdata, 0);
        step();
        step();
        reset_n = 1;
        step();
        chk("t5_no_ack", n_done[1], 0);
        gnt_log.delete();
        txq[0].push_back('{1'b1, 7'h50, 8'h33});
        txq[1].push_back('{1'b1, 7'h51, 8'h44});
        run_idle(30);
        chk("t5_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() > 0) chk("t5_first", gnt_log[0], 0);

        // m0 keeps req high in the IDLE cycle after its ack.
        clear_bfm();
        gnt_log.delete();
        b2b[0] = 1;
        txq[0].push_back('{1'b1, 7'h60, 8'h55});
        txq[0].push_back('{1'b1, 7'h60, 8'h55});
        run_idle(30);
        chk("t6_acks", n_done[0], 2);
        chk("t6_ngnt", gnt_log.size(), 2);
        b2b[0] = 0;

        // Random traffic from both masters.
        clear_bfm();
        gaps = 1;
        for (int i = 0; i < 40; i++) begin
            for (int m = 0; m < 2; m++) begin
                txq[m].push_back('{1'($urandom_range(0, 1)),
                                   7'($urandom_range(0, 15)),
                                   8'($urandom_range(0, 255))});
            end
        end
        run_idle(3000);
        chk("rnd_m0_done", n_done[0], 40);
        chk("rnd_m1_done", n_done[1], 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
